sc_speed_tick_scheduler: RTL and testbench

- Game-timing controller for the road/enemy scroll datapath.
- Maps a 6-bit progress level onto speed zones, each with a fixed tick period in milliseconds.
- Generates one-cycle tick pulses at the zone's rate from the 50 MHz clock.
- Sequences start, pause, hold and finish of the timing, and reports the active zone and tick count to the game FSM.

---
 rtl/sc_speed_tick_scheduler.sv | 129 ++++++++++++
 tb/tb_sc_speed_tick_scheduler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sc_speed_tick_scheduler.sv
// Speed-zone tick scheduler: maps the progress level onto a speed zone and emits
// one-cycle ticks at that zone's millisecond period, with start/pause/hold/finish sequencing.
module sc_speed_tick_scheduler #(
    parameter int PRESCALE_DIV = 50000,
    parameter int ZONE0_MS     = 350,
    parameter int ZONE2_MS     = 280,
    parameter int ZONE4_MS     = 200,
    parameter int PERIOD_W     = 10
) (
    input  logic       SC_SpeedTick_CLOCK_50,
    input  logic       SC_SpeedTick_RESET_InHigh,
    input  logic       SC_SpeedTick_start_InHigh,
    input  logic       SC_SpeedTick_pause_InHigh,
    input  logic [5:0] SC_SpeedTick_level_InBUS,
    output logic       SC_SpeedTick_tick_Out,
    output logic [2:0] SC_SpeedTick_zone_OutBUS,
    output logic       SC_SpeedTick_busy_Out,
    output logic       SC_SpeedTick_done_Out,
    output logic [7:0] SC_SpeedTick_tickcount_OutBUS
);

    localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]          stateReg, stateNext, resumeReg;
    logic [2:0]          zoneReg, zoneDec;
    logic [PRE_W-1:0]    prescaleCnt;
    logic [PERIOD_W-1:0] periodCnt, periodMs;
    logic                tickReg, busyReg, doneReg;
    logic [7:0]          tickCount;
    logic                msStrobe, periodEnd;
    logic                startAcc, zoneChg, pauseEnt, countEn;

    function automatic logic [2:0] zoneState(input logic [2:0] z);
        if (z == 3'd5)                   return ST_DONE;
        else if (z == 3'd1 || z == 3'd3) return ST_HOLD;
        else                             return ST_RUN;
    endfunction

    always_comb begin
        zoneDec = 3'd5;
        if (SC_SpeedTick_level_InBUS <= 6'd10)      zoneDec = 3'd0;
        else if (SC_SpeedTick_level_InBUS <= 6'd17) zoneDec = 3'd1;
        else if (SC_SpeedTick_level_InBUS <= 6'd32) zoneDec = 3'd2;
        else if (SC_SpeedTick_level_InBUS <= 6'd40) zoneDec = 3'd3;
        else if (SC_SpeedTick_level_InBUS <= 6'd60) zoneDec = 3'd4;
    end

    always_comb begin
        case (zoneReg)
            3'd2:    periodMs = PERIOD_W'(ZONE2_MS);
            3'd4:    periodMs = PERIOD_W'(ZONE4_MS);
            default: periodMs = PERIOD_W'(ZONE0_MS);
        endcase
    end

    assign msStrobe  = (prescaleCnt == PRE_W'(PRESCALE_DIV - 1));
    assign periodEnd = msStrobe && (periodCnt == periodMs - PERIOD_W'(1));

    assign startAcc = (stateReg == ST_IDLE || stateReg == ST_DONE) && SC_SpeedTick_start_InHigh;
    assign pauseEnt = (stateReg == ST_RUN || stateReg == ST_HOLD) && SC_SpeedTick_pause_InHigh;
    assign zoneChg  = (stateReg == ST_RUN || stateReg == ST_HOLD) && !SC_SpeedTick_pause_InHigh
                      && (zoneDec != zoneReg);
    // The resume edge already counts; the pause edge does not, so a paused
    // interval shifts the next tick by exactly the number of frozen edges.
    assign countEn  = !SC_SpeedTick_pause_InHigh &&
                      ((stateReg == ST_RUN && zoneDec == zoneReg) ||
                       (stateReg == ST_PAUSE && resumeReg == ST_RUN));

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE, ST_DONE: if (SC_SpeedTick_start_InHigh) stateNext = zoneState(zoneDec);
            ST_RUN, ST_HOLD: begin
                if (SC_SpeedTick_pause_InHigh) stateNext = ST_PAUSE;
                else if (zoneDec != zoneReg)   stateNext = zoneState(zoneDec);
            end
            ST_PAUSE: if (!SC_SpeedTick_pause_InHigh) stateNext = resumeReg;
            default:  stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge SC_SpeedTick_CLOCK_50 or posedge SC_SpeedTick_RESET_InHigh) begin
        if (SC_SpeedTick_RESET_InHigh) begin
            stateReg    <= ST_IDLE;
            resumeReg   <= ST_IDLE;
            zoneReg     <= 3'd0;
            prescaleCnt <= '0;
            periodCnt   <= '0;
            tickReg     <= 1'b0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
            tickCount   <= 8'd0;
        end else begin
            stateReg <= stateNext;
            busyReg  <= (stateNext == ST_RUN) || (stateNext == ST_HOLD) || (stateNext == ST_PAUSE);
            doneReg  <= (stateNext == ST_DONE);
            tickReg  <= 1'b0;
            if (pauseEnt) resumeReg <= stateReg;
            if (startAcc || zoneChg) begin
                zoneReg     <= zoneDec;
                prescaleCnt <= '0;
                periodCnt   <= '0;
                if (startAcc) tickCount <= 8'd0;
            end else if (countEn) begin
                prescaleCnt <= msStrobe ? '0 : prescaleCnt + PRE_W'(1);
                if (periodEnd) begin
                    periodCnt <= '0;
                    tickReg   <= 1'b1;
                    if (tickCount != 8'hFF) tickCount <= tickCount + 8'd1;
                end else if (msStrobe) begin
                    periodCnt <= periodCnt + PERIOD_W'(1);
                end
            end
        end
    end

    assign SC_SpeedTick_tick_Out         = tickReg;
    assign SC_SpeedTick_zone_OutBUS      = zoneReg;
    assign SC_SpeedTick_busy_Out         = busyReg;
    assign SC_SpeedTick_done_Out         = doneReg;
    assign SC_SpeedTick_tickcount_OutBUS = tickCount;

endmodule

// File: tb/tb_sc_speed_tick_scheduler.sv
// Bench for sc_speed_tick_scheduler: vector table, directed timing sequences and a
// randomized run checked against a countdown-based reference model.
module tb_sc_speed_tick_scheduler;
    localparam int P = 4, Z0 = 3, Z2 = 2, Z4 = 1;
    localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_PAUSE = 3, S_DONE = 4;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0;
    logic [5:0] level = 6'd0;
    logic       tick, busy, done;
    logic [2:0] zone;
    logic [7:0] tc;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sc_speed_tick_scheduler #(.PRESCALE_DIV(P), .ZONE0_MS(Z0), .ZONE2_MS(Z2), .ZONE4_MS(Z4),
                              .PERIOD_W(10)) dut (
        .SC_SpeedTick_CLOCK_50(clk), .SC_SpeedTick_RESET_InHigh(rst),
        .SC_SpeedTick_start_InHigh(start), .SC_SpeedTick_pause_InHigh(pause),
        .SC_SpeedTick_level_InBUS(level), .SC_SpeedTick_tick_Out(tick),
        .SC_SpeedTick_zone_OutBUS(zone), .SC_SpeedTick_busy_Out(busy),
        .SC_SpeedTick_done_Out(done), .SC_SpeedTick_tickcount_OutBUS(tc));

    // Reference model: a plain cycles-until-next-tick countdown per zone.
    typedef struct packed { int st; int res; int zone; int remain; int tick; int tc; } model_t;
    model_t m;

    function automatic int zoneOf(int lv);
        if (lv <= 10) return 0; else if (lv <= 17) return 1; else if (lv <= 32) return 2;
        else if (lv <= 40) return 3; else if (lv <= 60) return 4; else return 5;
    endfunction
    function automatic int perOf(int z);
        return (z == 0) ? Z0 : (z == 2) ? Z2 : Z4;
    endfunction
    function automatic int stOf(int z);
        return (z == 5) ? S_DONE : (z == 1 || z == 3) ? S_HOLD : S_RUN;
    endfunction
    function automatic model_t adv(model_t a);
        model_t n = a;
        n.remain = a.remain - 1;
        if (n.remain <= 0) begin
            n.tick = 1; n.tc = (a.tc < 255) ? a.tc + 1 : 255; n.remain = P * perOf(a.zone);
        end
        return n;
    endfunction
    function automatic model_t mstep(model_t a, int lv, bit s, bit p);
        model_t n = a;
        int z = zoneOf(lv);
        n.tick = 0;
        case (a.st)
            S_IDLE, S_DONE: if (s) begin
                n.zone = z; n.remain = P * perOf(z); n.tc = 0; n.st = stOf(z);
            end
            S_RUN, S_HOLD: begin
                if (p) begin n.res = a.st; n.st = S_PAUSE; end
                else if (z != a.zone) begin n.zone = z; n.remain = P * perOf(z); n.st = stOf(z); end
                else if (a.st == S_RUN) n = adv(n);
            end
            S_PAUSE: if (!p) begin n.st = a.res; if (a.res == S_RUN) n = adv(n); end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) m <= '0;
        else     m <= mstep(m, int'(level), start, pause);

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk); @(negedge clk);
    endtask
    task automatic doReset();
        @(negedge clk); rst = 1'b1; start = 1'b0; pause = 1'b0;
        step(); rst = 1'b0;
    endtask
    function automatic int expTick(int k, int first, int per);
        return (k >= first && (k - first) % per == 0) ? 1 : 0;
    endfunction

    typedef struct { logic [5:0] lv; bit st; bit pa; int tk; int zn; int bz; int dn; int tcv; } vec_t;
    vec_t vt[16];

    initial begin
        int nt;
        vt[0]  = '{6'd12, 1, 0, 0, 1, 1, 0, 0};
        vt[1]  = '{6'd12, 0, 0, 0, 1, 1, 0, 0};
        vt[2]  = '{6'd62, 0, 0, 0, 5, 0, 1, 0};
        vt[3]  = '{6'd0,  1, 0, 0, 0, 1, 0, 0};
        vt[4]  = '{6'd0,  0, 1, 0, 0, 1, 0, 0};
        vt[5]  = '{6'd40, 0, 1, 0, 0, 1, 0, 0};
        vt[6]  = '{6'd40, 0, 0, 0, 0, 1, 0, 0};
        vt[7]  = '{6'd40, 0, 0, 0, 3, 1, 0, 0};
        vt[8]  = '{6'd45, 0, 0, 0, 4, 1, 0, 0};
        vt[9]  = '{6'd45, 0, 0, 0, 4, 1, 0, 0};
        vt[10] = '{6'd45, 0, 0, 0, 4, 1, 0, 0};
        vt[11] = '{6'd45, 0, 0, 0, 4, 1, 0, 0};
        vt[12] = '{6'd45, 0, 0, 1, 4, 1, 0, 1};
        vt[13] = '{6'd45, 1, 0, 0, 4, 1, 0, 1};
        vt[14] = '{6'd63, 0, 0, 0, 5, 0, 1, 1};
        vt[15] = '{6'd63, 1, 0, 0, 5, 0, 1, 0};

        #1;
        chk("rst_tick", tick, 0); chk("rst_zone", zone, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_tc", tc, 0);
        step(); rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            level = vt[i].lv; start = vt[i].st; pause = vt[i].pa;
            step();
            chk($sformatf("vec%0d_tick", i), tick, vt[i].tk);
            chk($sformatf("vec%0d_zone", i), zone, vt[i].zn);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].bz);
            chk($sformatf("vec%0d_done", i), done, vt[i].dn);
            chk($sformatf("vec%0d_tc", i), tc, vt[i].tcv);
        end
        start = 1'b0;

        // Zone 0 from DONE: ticks every 12 cycles
        level = 6'd5; start = 1'b1; step(); start = 1'b0;
        chk("a_zone", zone, 0); chk("a_busy", busy, 1); chk("a_tc0", tc, 0);
        for (int k = 1; k <= 36; k++) begin step(); chk($sformatf("a_tick%0d", k), tick, expTick(k, 12, 12)); end
        chk("a_tc3", tc, 3);

        // Zone change 0 -> 2 mid-period restarts timing
        doReset(); level = 6'd5; start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 6; k++) begin step(); chk("b_pre_tick", tick, 0); end
        level = 6'd20; step(); chk("b_zone", zone, 2); chk("b_chg_tick", tick, 0);
        for (int k = 1; k <= 16; k++) begin step(); chk($sformatf("b_tick%0d", k), tick, expTick(k, 8, 8)); end

        // Pause for 10 cycles in zone 4
        doReset(); level = 6'd45; start = 1'b1; step(); start = 1'b0;
        step(); chk("c_tick1", tick, 0);
        pause = 1'b1;
        for (int k = 2; k <= 11; k++) begin step(); chk("c_ptick", tick, 0); chk("c_pbusy", busy, 1); end
        pause = 1'b0;
        for (int k = 12; k <= 20; k++) begin step(); chk($sformatf("c_tick%0d", k), tick, expTick(k, 14, 4)); end

        // HOLD zone then release into zone 0, then finish and restart
        doReset(); level = 6'd12; start = 1'b1; step(); start = 1'b0;
        chk("d_zone", zone, 1); chk("d_busy", busy, 1);
        nt = 0;
        for (int k = 0; k < 50; k++) begin step(); nt += int'(tick); end
        chk("d_hold_ticks", nt, 0);
        level = 6'd8; step(); chk("d_zone0", zone, 0);
        for (int k = 1; k <= 12; k++) begin step(); chk($sformatf("d_tick%0d", k), tick, expTick(k, 12, 12)); end
        level = 6'd62; step();
        chk("e_done", done, 1); chk("e_busy", busy, 0); chk("e_zone", zone, 5);
        nt = 0;
        for (int k = 0; k < 20; k++) begin step(); nt += int'(tick); end
        chk("e_ticks", nt, 0); chk("e_tc_hold", tc, 1);
        level = 6'd0; start = 1'b1; step(); start = 1'b0;
        chk("e_tc0", tc, 0); chk("e_busy2", busy, 1); chk("e_done2", done, 0);

        // Asynchronous reset between ticks
        doReset(); level = 6'd20; start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("f_tc_pre", tc, 2);
        #2 rst = 1'b1; #1;
        chk("f_tick", tick, 0); chk("f_zone", zone, 0); chk("f_busy", busy, 0);
        chk("f_done", done, 0); chk("f_tc", tc, 0);
        @(negedge clk); rst = 1'b0;
        nt = 0;
        for (int k = 0; k < 20; k++) begin step(); nt += int'(tick); end
        chk("f_noticks", nt, 0); chk("f_busy_after", busy, 0);

        // Saturation
        doReset(); level = 6'd45; start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 1200; k++) step();
        chk("g_sat", tc, 255);

        // Randomized run against the reference model
        doReset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) level = 6'($urandom_range(0, 63));
            start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            step();
            chk("r_tick", tick, m.tick); chk("r_zone", zone, m.zone);
            chk("r_busy", busy, (m.st == S_RUN || m.st == S_HOLD || m.st == S_PAUSE) ? 1 : 0);
            chk("r_done", done, (m.st == S_DONE) ? 1 : 0);
            chk("r_tc", tc, m.tc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
